mem_stream_reader: RTL and testbench

- Read-side master for the single-port RAM. The RAM gives combinational read data and a synchronous write.
- On a start command it walks a contiguous address range and presents each word on a valid/ready output stream. The consumer is typically the HD encoder/similarity datapath.
- A 2-entry output buffer decouples RAM reads from consumer backpressure and sustains 1 word/cycle.

---
 rtl/hd_mem_pkg.sv | 14 +
 rtl/mem_skid_fifo.sv | 67 ++++++
 rtl/mem_stream_reader.sv | 110 +++++++++++
 tb/tb_mem_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_mem_pkg.sv
// Shared types and default widths for the HD memory read-side logic.
package hd_mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/mem_skid_fifo.sv
// Two-entry synchronous FIFO; accepts a push while full when a pop happens in the same cycle.
module mem_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the consumer only looks at it through count/empty.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign pop_data = slot_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Walks a contiguous RAM address range on start and streams each word out over valid/ready.
module mem_stream_reader #(
    parameter int DATA_WIDTH = hd_mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = hd_mem_pkg::ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);
    import hd_mem_pkg::*;

    localparam int                BUF_W     = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] REM_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    reader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  issue, pop;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_count;
    logic [BUF_W-1:0]      head;

    assign pop   = !fifo_empty && out_ready;
    assign issue = (state_q == READ) && (!fifo_full || pop);

    mem_skid_fifo #(
        .WIDTH(BUF_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_data({mem_rdata, rem_q == REM_ONE}),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        addr_hold_d = addr_hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    rem_d   = (len > DEPTH_LEN) ? DEPTH_LEN : len;
                    state_d = (rem_d == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_hold_d = ptr_q;
                    ptr_d       = ptr_q + ADDR_WIDTH'(1);
                    rem_d       = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final word is being accepted, so done follows it directly.
                if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    // Outside READ the address parks on the last word actually read.
    assign mem_addr  = (state_q == READ) ? ptr_q : addr_hold_q;
    assign mem_we    = 1'b0;
    assign busy      = (state_q == READ) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head[BUF_W-1:1] : '0;
    assign out_last  = out_valid && head[0];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized scoreboard bench for mem_stream_reader with a queue-based reference model.
module tb_mem_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    logic [DW-1:0] ram [DEPTH];
    word_t         exp_q[$];
    int            addr_log[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            ready_mode = 0;
    bit            spurious_en = 1'b0;
    bit            seen_valid = 1'b0;
    int            first_valid_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    mem_stream_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    assign mem_rdata = ram[mem_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer: always ready, alternating, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and watches stall stability.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (mem_we !== 1'b0) check("mem_we", mem_we, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && !seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (busy && (addr_log.size() == 0 || addr_log[$] != int'(mem_addr)))
                addr_log.push_back(int'(mem_addr));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got data %0d, expected no word", out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.d);
                    check("out_last", out_last, w.l);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_cmd(input int b, input int l, input bit chk_lat);
        int    n;
        int    start_cyc;
        int    done_cyc;
        int    bad_idx;
        bit    got;
        word_t w;
        n = (l > DEPTH) ? DEPTH : l;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            w.d = ram[(b + i) % DEPTH];
            w.l = (i == n - 1);
            exp_q.push_back(w);
        end
        addr_log.delete();
        seen_valid = 1'b0;
        start      = 1'b1;
        base_addr  = AW'(b);
        len        = (AW + 1)'(l);
        start_cyc  = cyc;
        got        = 1'b0;
        done_cyc   = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                got      = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (spurious_en && busy && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                len       = (AW + 1)'($urandom);
            end
        end
        check("done_seen", got, 1);
        if (!got) begin
            exp_q.delete();
            return;
        end
        check("busy_in_done", busy, 0);
        if (chk_lat) check("done_latency", done_cyc - start_cyc, (n == 0) ? 1 : n + 2);
        if (n > 0) check("first_valid_latency", first_valid_cyc - start_cyc, 2);
        else check("no_valid_for_len0", seen_valid, 0);
        check("words_outstanding", exp_q.size(), 0);
        exp_q.delete();
        check("addr_seq_len", addr_log.size(), n);
        bad_idx = -1;
        for (int i = 0; i < addr_log.size() && i < n; i++)
            if (bad_idx < 0 && addr_log[i] != (b + i) % DEPTH) bad_idx = i;
        check("addr_seq_first_bad", bad_idx, -1);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        bit ok;
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        start     = 1'b1;
        base_addr = 8'd7;
        len       = 9'd3;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(3 * i + 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_we", mem_we, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_done", done, 0);

        ready_mode = 0;
        run_cmd(4, 5, 1'b1);
        ready_mode = 1;
        run_cmd(4, 5, 1'b0);
        ready_mode = 0;
        run_cmd(254, 4, 1'b1);
        run_cmd(77, 0, 1'b1);
        run_cmd(0, 300, 1'b1);
        ready_mode = 2;
        run_cmd(17, 256, 1'b0);

        spurious_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int b, l, m;
            for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
            b = $urandom_range(0, DEPTH - 1);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 20);
            m = $urandom_range(0, 2);
            ready_mode = m;
            run_cmd(b, l, m == 0);
        end
        spurious_en = 1'b0;

        ready_mode = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'd10;
        len       = 9'd50;
        for (int i = 0; i < 50; i++) begin
            word_t w;
            w.d = ram[10 + i];
            w.l = (i == 49);
            exp_q.push_back(w);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_before_reset", ok, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(1000 + 7 * i);
        run_cmd(250, 9, 1'b1);
        ready_mode = 2;
        run_cmd(33, 12, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
